// File: rtl/touch_sensor_array.sv
// Multi-channel touch front end: per-channel synchroniser, debouncer, press/release/long-press
// event pulses and a latching toggle. Every output comes straight from a flop.
module touch_sensor_array #(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int LONG_CYC     = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] touch_in,
    input  logic            enable,
    output logic [N_CH-1:0] touched,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] toggle_state,
    output logic            any_touched
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int H_W  = $clog2(LONG_CYC + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [H_W-1:0]  H_MAX   = H_W'(LONG_CYC);
    localparam logic [H_W-1:0]  H_LAST  = H_W'(LONG_CYC - 1);

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_s;
    logic [DB_W-1:0] db_cnt_q [N_CH];
    logic [DB_W-1:0] db_cnt_d [N_CH];
    logic [H_W-1:0]  hold_cnt_q [N_CH];
    logic [H_W-1:0]  hold_cnt_d [N_CH];
    logic [N_CH-1:0] touched_q, touched_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [N_CH-1:0] toggle_q, toggle_d;
    logic [N_CH-1:0] long_done_q, long_done_d;
    logic            any_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Per-channel debounce, hold timing and event generation.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            db_cnt_d[ch]    = '0;
            hold_cnt_d[ch]  = '0;
            touched_d[ch]   = touched_q[ch];
            toggle_d[ch]    = toggle_q[ch];
            press_d[ch]     = 1'b0;
            release_d[ch]   = 1'b0;
            long_d[ch]      = 1'b0;
            if (enable) begin
                if (sync_s[ch] != touched_q[ch]) begin
                    if (db_cnt_q[ch] == DB_LAST) begin
                        touched_d[ch] = sync_s[ch];
                        press_d[ch]   = sync_s[ch];
                        release_d[ch] = ~sync_s[ch];
                        toggle_d[ch]  = toggle_q[ch] ^ sync_s[ch];
                    end else begin
                        db_cnt_d[ch] = db_cnt_q[ch] + DB_W'(1);
                    end
                end else begin
                    db_cnt_d[ch] = '0;
                end
                if (touched_q[ch]) begin
                    if (hold_cnt_q[ch] != H_MAX) begin
                        hold_cnt_d[ch] = hold_cnt_q[ch] + H_W'(1);
                    end else begin
                        hold_cnt_d[ch] = hold_cnt_q[ch];
                    end
                    // An enable gap restarts the hold count; the done flag keeps it to one pulse per press.
                    long_d[ch] = (hold_cnt_q[ch] == H_LAST) && !long_done_q[ch] && !release_d[ch];
                end else begin
                    hold_cnt_d[ch] = '0;
                end
            end else begin
                db_cnt_d[ch] = '0;
            end
            if (!touched_q[ch]) begin
                long_done_d[ch] = 1'b0;
            end else if (long_d[ch]) begin
                long_done_d[ch] = 1'b1;
            end else begin
                long_done_d[ch] = long_done_q[ch];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                db_cnt_q[ch]   <= '0;
                hold_cnt_q[ch] <= '0;
            end
            touched_q   <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            toggle_q    <= '0;
            long_done_q <= '0;
            any_q       <= 1'b0;
        end else begin
            sync_q[0] <= touch_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                db_cnt_q[ch]   <= db_cnt_d[ch];
                hold_cnt_q[ch] <= hold_cnt_d[ch];
            end
            touched_q   <= touched_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            toggle_q    <= toggle_d;
            long_done_q <= long_done_d;
            any_q       <= |touched_q;
        end
    end

    assign touched       = touched_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign toggle_state  = toggle_q;
    assign any_touched   = any_q;

endmodule
